// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state enum, the queue entry layout and the PC step helper.
package instr_fetch_pkg;

  localparam int          IMEM_DATA_W = 32;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [IMEM_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: 2-entry registered FIFO of {pc, instr}; output valid the cycle after a push.
// Flush wins over same-cycle push/pop; the producer guarantees no push when full without a pop.
module fetch_queue
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & valid & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload needs no reset: it is only observed while cnt says the slot is live.
  always_ff @(posedge clk) begin
    if (do_push) slot[wr_ptr] <= push_data;
  end

  assign head  = slot[rd_ptr];
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + imem requester (<=2 in flight), 2-entry output queue, word->decode latency 1 cycle,
// stalls requests on queue+in-flight credit; IFETCH_ALIGN_CHECK_EN enables the misaligned-redirect fault.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [IMEM_DATA_W-1:0] imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IMEM_DATA_W-1:0] out_instr,
  output logic [31:0]            out_pc,
  output logic                   fetch_fault
);

  ifetch_state_t state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [1:0]    outstanding;
  logic [1:0]    drop_count;
  logic [31:0]   target_pc;
  logic          misaligned;
  logic          issue;
  logic          rsp_keep;
  logic          pop;
  logic          credit_ok;
  logic [2:0]    occupancy;
  logic [1:0]    q_count;
  logic          q_valid;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target_pc  = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign target_pc  = {redirect_pc[31:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  assign pop      = q_valid & out_ready;
  assign issue    = imem_req & imem_gnt;
  assign rsp_keep = imem_rvalid & (drop_count == 2'd0) & ~redirect_valid;

  // A same-cycle pop frees its slot in time for a word requested now, which is what sustains 1 IPC.
  assign occupancy = {1'b0, q_count} - {2'b0, pop} + {1'b0, outstanding};
  assign credit_ok = occupancy < 3'(MAX_OUTSTANDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid && misaligned) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        IDLE:    if (fetch_en)       state_nxt = RUN;
        RUN:     if (!fetch_en)      state_nxt = IDLE;
        FAULT:   if (redirect_valid) state_nxt = RUN;
        default:                     state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state == RUN) & ~redirect_valid & credit_ok;
    imem_addr = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      drop_count  <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, issue} - {1'b0, imem_rvalid};
      if (redirect_valid) begin
        pc         <= target_pc;
        resp_pc    <= target_pc;
        // Everything still in flight after this cycle belongs to the old path.
        drop_count <= outstanding - {1'b0, imem_rvalid};
      end else begin
        if (issue)    pc      <= pc_next(pc);
        if (rsp_keep) resp_pc <= pc_next(resp_pc);
        if (imem_rvalid && drop_count != 2'd0) drop_count <= drop_count - 2'd1;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= misaligned;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign q_in = '{pc: resp_pc, instr: imem_rdata};

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  assign out_valid = q_valid;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;

endmodule
